// File: rtl/fpu_pkg.sv
// Shared FPU types: result payload, exception flag layout and width constants.
package fpu_pkg;

  localparam int unsigned FPU_EXP_W  = 8;
  localparam int unsigned FPU_MAN_W  = 24;
  localparam int unsigned FPU_DATA_W = FPU_EXP_W + FPU_MAN_W;
  localparam int unsigned FPU_TAG_W  = 4;
  localparam int unsigned FPU_FLAG_W = 5;

  // Bit positions of each exception flag inside the packed 5-bit vector.
  localparam int unsigned FLAG_NV = 4;
  localparam int unsigned FLAG_DZ = 3;
  localparam int unsigned FLAG_OF = 2;
  localparam int unsigned FLAG_UF = 1;
  localparam int unsigned FLAG_NX = 0;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fpu_flags_t;

  typedef struct packed {
    logic [FPU_DATA_W-1:0] data;
    fpu_flags_t            flags;
    logic [FPU_TAG_W-1:0]  tag;
  } fpu_result_t;

endpackage

// File: rtl/fpu_result_queue.sv
// Write-back FIFO between the FPU controller and the CPU. Captures each result on
// reg_we, presents it with valid/ready, and signals free space back via cpu_ready.
// Width parameters are expected to match the fpu_pkg constants used by the payload.
module fpu_result_queue
  import fpu_pkg::*;
#(
  parameter int unsigned EXP_WIDTH = FPU_EXP_W,
  parameter int unsigned MAN_WIDTH = FPU_MAN_W,
  parameter int unsigned TAG_WIDTH = FPU_TAG_W,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           reg_we,
  input  logic [EXP_WIDTH+MAN_WIDTH-1:0] res_data_i,
  input  logic [FPU_FLAG_W-1:0]          res_flags_i,
  input  logic [TAG_WIDTH-1:0]           tag_i,
  input  logic                           flush,
  output logic                           cpu_ready,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [EXP_WIDTH+MAN_WIDTH-1:0] out_data,
  output logic [FPU_FLAG_W-1:0]          out_flags,
  output logic [TAG_WIDTH-1:0]           out_tag,
  output logic [$clog2(DEPTH):0]         level,
  output logic                           ovf_err
);

  localparam int unsigned DATA_W = EXP_WIDTH + MAN_WIDTH;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;

  fpu_result_t      r_mem [DEPTH];

  logic             w_full;
  logic             w_nonempty;
  logic             w_push;
  logic             w_pop;
  logic             w_accept;
  logic             w_drop;
  fpu_result_t      w_entry;
  fpu_result_t      w_head;

  // Handshake qualification: flush overrides both push and pop.
  always_comb begin
    w_full     = (r_count == CNT_W'(DEPTH));
    w_nonempty = (r_count != '0);
    w_push     = reg_we & ~flush;
    w_pop      = w_nonempty & out_ready & ~flush;
    // A full queue still accepts a push when the head leaves in the same cycle.
    w_accept   = w_push & (~w_full | w_pop);
    w_drop     = w_push & w_full & ~w_pop;
  end

  // Pack the incoming result into the shared payload type.
  always_comb begin
    w_entry       = '0;
    w_entry.data  = FPU_DATA_W'(res_data_i);
    w_entry.flags = fpu_flags_t'(res_flags_i);
    w_entry.tag   = FPU_TAG_W'(tag_i);
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_accept && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_accept && w_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Sticky overflow: set when a push is dropped, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end
  end

  // Payload storage, intentionally not reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  // Output view derived only from registered state.
  always_comb begin
    w_head    = r_mem[r_rd_ptr];
    cpu_ready = ~w_full;
    out_valid = w_nonempty;
    out_data  = DATA_W'(w_head.data);
    out_flags = FPU_FLAG_W'(w_head.flags);
    out_tag   = TAG_WIDTH'(w_head.tag);
    level     = r_count;
    ovf_err   = r_ovf;
  end

endmodule

// File: doc/fpu_result_queue.md
# fpu_result_queue

Result write-back queue sitting directly downstream of the FPU controller/datapath. It captures each completed result (value, exception flags, tag) on the controller's register-write strobe and buffers it in a small FIFO. It presents results to the CPU with a valid/ready handshake and drives `cpu_ready` back to the controller, so a new operation is accepted only when a slot is guaranteed free.

## Interface
- `EXP_WIDTH`, 8, exponent width.
- `MAN_WIDTH`, 24, mantissa width including hidden bit; result width `DATA_W = EXP_WIDTH + MAN_WIDTH` (32).
- `TAG_WIDTH`, 4, operation tag width.
- `DEPTH`, 4, queue entries; power of two, ≥2.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `reg_we`  in  1  push strobe from controller; one cycle per completed op.
- `res_data_i`  in  DATA_W  datapath result, valid while `reg_we`=1.
- `res_flags_i`  in  5  exception flags {NV,DZ,OF,UF,NX}, valid with `reg_we`.
- `tag_i`  in  TAG_WIDTH  registered tag from controller, valid with `reg_we`.
- `flush`  in  1  synchronous queue clear.
- `cpu_ready`  out  1  to controller: a free slot exists.
- `out_valid`  out  1  head entry available.
- `out_ready`  in  1  CPU consumes head.
- `out_data`  out  DATA_W  head result.
- `out_flags`  out  5  head flags.
- `out_tag`  out  TAG_WIDTH  head tag.
- `level`  out  $clog2(DEPTH)+1  occupied entries.
- `ovf_err`  out  1  sticky: push dropped while full.

## Operation
- Circular buffer: `wr_ptr` and `rd_ptr` of $clog2(DEPTH) bits wrap modulo DEPTH; `count` of $clog2(DEPTH)+1 bits.
- push = `reg_we` && !`flush`; pop = `out_valid` && `out_ready` && !`flush`.
- Push when `count` < DEPTH: write entry at `wr_ptr`, `wr_ptr`++.
- Push when `count` == DEPTH with pop in the same cycle: accepted; `count` unchanged.
- Push when full without pop: entry dropped, pointers unchanged, `ovf_err` set to 1 until `rst`. Flush does not clear it.
- Pop: `rd_ptr`++. Simultaneous push and pop leaves `count` unchanged.
- `cpu_ready` = (`count` < DEPTH), combinational from the register. The controller has at most one op in flight, and `count` can only fall until that op's push, so an accepted op always finds a slot.
- `out_valid` = (`count` != 0). `out_data`, `out_flags`, `out_tag` read storage at `rd_ptr`. Contents are held stable while `out_valid` && !`out_ready`.
- `flush`: `count`, `wr_ptr` and `rd_ptr` go to 0 next cycle. Flush wins over a coincident push or pop, and that push is lost without setting `ovf_err`.
- Storage array is not reset. Outputs are don't-care when `out_valid`=0.

## Timing
- Reset (`rst`=1 at an edge): `count`=0, pointers=0, `ovf_err`=0. Next cycle `out_valid`=0, `cpu_ready`=1, `level`=0, data outputs don't-care.
- Reset mid-operation discards all entries, including a coincident push.
- Push latency: `reg_we` sampled at edge N gives `out_valid`=1 after edge N, for an empty queue. This coincides with the controller's `res_valid` cycle.
- No combinational path from `reg_we` or `out_ready` to any output. `cpu_ready` is registered-state only.
- Pop takes effect at the edge where `out_valid` && `out_ready`. The next entry, if any, is presented the following cycle.
- Throughput: one push and one pop per cycle.

## Structure
- Shared package `fpu_pkg`:
  - `fpu_flags_t` (packed 5-bit struct: nv, dz, of, uf, nx).
  - `fpu_result_t` (data, flags, tag).
  - Flag bit-index constants.
- The controller and datapath use the same package types.
- Single module; storage is an inline array of `fpu_result_t` with pointer/count logic. No sub-module.

## Test plan
- Reset then idle: `rst` high 2 cycles → `out_valid`=0, `cpu_ready`=1, `level`=0, `ovf_err`=0.
- Single push: `reg_we` with data 32'h3F800000, flags 5'b00001, tag 4'h7, `out_ready`=1 → next cycle `out_valid`=1 with those values; popped; following cycle `out_valid`=0.
- Fill and backpressure: 4 pushes (tags 1..4), `out_ready`=0 → `level`=4, `cpu_ready`=0, head tag 1. Release `out_ready` → tags 1,2,3,4 delivered in order, one per cycle. `cpu_ready` returns to 1 after the first pop.
- Full with simultaneous push+pop: at `level`=4, assert `reg_we` (tag 5) and `out_ready` → `level` stays 4, tag 1 popped, tag 5 appears last; `ovf_err`=0.
- Overflow: at `level`=4, `reg_we` with `out_ready`=0 → entry dropped, `level`=4, `ovf_err`=1 and remains 1 after `flush`.
- Wrap and flush: 6 push/pop pairs to wrap the pointers, then `flush` coincident with `reg_we` → next cycle `level`=0, `out_valid`=0. A later push of tag 9 is delivered correctly.
